// File: rtl/gate_seq_pkg.sv
// Shared types and truth-table constants for the gate truth-table sequencer.
package gate_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  // Bit i is the required gate output for input vector i (bit 0 = A, bit 1 = B).
  localparam logic [3:0] TT_OR2  = 4'b1110;
  localparam logic [3:0] TT_AND2 = 4'b1000;
  localparam logic [3:0] TT_XOR2 = 4'b0110;
  localparam logic [3:0] TT_NOR2 = 4'b0001;

endpackage

// File: rtl/gate_seq_settle_ctr.sv
// Loadable 4-bit down-counter timing the settle window between APPLY and CHECK.
module gate_seq_settle_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] count,
  output logic       zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/gate_truth_sequencer.sv
// Walks a small gate through every input vector, checks its output against a
// truth table, and reports per-vector mismatches, an error count and pass/fail.
//
// state     | meaning
// ST_IDLE   | gate inputs parked at 0, waiting for start
// ST_APPLY  | drive the current vector, settle counter loaded
// ST_SETTLE | hold the vector while the settle counter runs down
// ST_CHECK  | compare gate_out with the expected bit for this vector
// ST_DONE   | one-cycle done pulse, pass valid
module gate_truth_sequencer
  import gate_seq_pkg::*;
#(
  parameter int                      N_IN   = 2,
  parameter int                      SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0]    EXPECT = TT_OR2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] gate_in,
  input  logic            gate_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            mismatch,
  output logic [N_IN-1:0] mismatch_vec
);

  localparam logic [N_IN-1:0] LAST_VEC  = '1;
  localparam logic [3:0]      SETTLE_LD = 4'(SETTLE);

  state_e          state;
  logic [N_IN-1:0] idx;
  logic            accept;
  logic            miss;
  logic [N_IN:0]   err_next;
  logic            ctr_load;
  logic [3:0]      ctr_count;
  logic            ctr_zero;

  // The DONE cycle already has the gate parked and busy low, so it doubles as
  // the idle gap when start is held for back-to-back runs.
  assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign miss     = (state == ST_CHECK) && (gate_out != EXPECT[idx]);
  assign err_next = err_count + {{N_IN{1'b0}}, miss};
  assign ctr_load = accept || ((state == ST_CHECK) && (idx != LAST_VEC));

  gate_seq_settle_ctr u_settle_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (SETTLE_LD),
    .dec      (state == ST_SETTLE),
    .count    (ctr_count),
    .zero     (ctr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      gate_in      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      mismatch     <= 1'b0;
      mismatch_vec <= '0;
    end else begin
      done     <= 1'b0;
      mismatch <= 1'b0;
      if (accept) begin
        state        <= ST_APPLY;
        idx          <= '0;
        gate_in      <= '0;
        busy         <= 1'b1;
        pass         <= 1'b0;
        err_count    <= '0;
        mismatch_vec <= '0;
      end else begin
        case (state)
          ST_IDLE:   state <= ST_IDLE;
          ST_APPLY:  state <= ctr_zero ? ST_CHECK : ST_SETTLE;
          ST_SETTLE: if (ctr_count == 4'd1) state <= ST_CHECK;
          ST_CHECK: begin
            if (miss) begin
              err_count    <= err_next;
              mismatch     <= 1'b1;
              mismatch_vec <= idx;
            end
            if (idx == LAST_VEC) begin
              state   <= ST_DONE;
              done    <= 1'b1;
              pass    <= (err_next == '0);
              busy    <= 1'b0;
              gate_in <= '0;
            end else begin
              state   <= ST_APPLY;
              idx     <= idx + 1'b1;
              gate_in <= idx + 1'b1;
            end
          end
          ST_DONE:   state <= ST_IDLE;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Directed bench: default OR sequencer driven by a selectable gate model, plus a zero-settle instance.
module tb_gate_truth_sequencer;
  import gate_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic [1:0] gi_a, gi_b, mv_a, mv_b;
  logic       go_a, go_b;
  logic       busy_a, done_a, pass_a, mm_a;
  logic       busy_b, done_b, pass_b, mm_b;
  logic [2:0] err_a, err_b;
  int         mode;  // 0 = OR gate, 1 = AND gate, 2 = stuck-at-0
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    go_a = |gi_a;
    case (mode)
      1:       go_a = &gi_a;
      2:       go_a = 1'b0;
      default: go_a = |gi_a;
    endcase
  end
  assign go_b = |gi_b;

  gate_truth_sequencer #(.N_IN(2), .SETTLE(2), .EXPECT(TT_OR2)) u_dut (
    .clk(clk), .rst(rst), .start(start_a), .gate_in(gi_a), .gate_out(go_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .mismatch(mm_a), .mismatch_vec(mv_a));

  gate_truth_sequencer #(.N_IN(2), .SETTLE(0), .EXPECT(TT_OR2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_b), .gate_in(gi_b), .gate_out(go_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .mismatch(mm_b), .mismatch_vec(mv_b));

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode = 0;
    repeat (2) @(negedge clk);
    n_checks++; if ({gi_a, busy_a, done_a, pass_a, err_a, mm_a, mv_a} !== 11'd0) begin
      n_fail++; $display("FAIL reset_a: outputs %b expected 0", {gi_a, busy_a, done_a, pass_a, err_a, mm_a, mv_a}); end
    n_checks++; if ({gi_b, busy_b, done_b, pass_b, err_b, mm_b, mv_b} !== 11'd0) begin
      n_fail++; $display("FAIL reset_b: outputs %b expected 0", {gi_b, busy_b, done_b, pass_b, err_b, mm_b, mv_b}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_or_pass();
    logic [1:0] exp_gi;
    mode = 0;
    start_a = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      exp_gi = (k < 16) ? 2'(k / 4) : 2'd0;
      n_checks++; if (gi_a !== exp_gi) begin
        n_fail++; $display("FAIL or_gate_in k=%0d: got %0d expected %0d", k, gi_a, exp_gi); end
      n_checks++; if (done_a !== (k == 16)) begin
        n_fail++; $display("FAIL or_done k=%0d: got %b expected %b", k, done_a, (k == 16)); end
      n_checks++; if (busy_a !== (k < 16)) begin
        n_fail++; $display("FAIL or_busy k=%0d: got %b expected %b", k, busy_a, (k < 16)); end
      n_checks++; if (mm_a !== 1'b0) begin
        n_fail++; $display("FAIL or_mismatch k=%0d: got %b expected 0", k, mm_a); end
      if (k == 16) begin
        n_checks++; if (pass_a !== 1'b1) begin
          n_fail++; $display("FAIL or_pass: got %b expected 1", pass_a); end
        n_checks++; if (err_a !== 3'd0) begin
          n_fail++; $display("FAIL or_err_count: got %0d expected 0", err_a); end
      end
    end
  endtask

  task automatic test_and_mismatch();
    mode = 1;
    start_a = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      n_checks++; if (mm_a !== (k == 8 || k == 12)) begin
        n_fail++; $display("FAIL and_mismatch k=%0d: got %b expected %b", k, mm_a, (k == 8 || k == 12)); end
      if (k == 8) begin
        n_checks++; if (mv_a !== 2'd1) begin
          n_fail++; $display("FAIL and_mismatch_vec1: got %0d expected 1", mv_a); end
      end
      if (k == 16) begin
        n_checks++; if (done_a !== 1'b1) begin
          n_fail++; $display("FAIL and_done: got %b expected 1", done_a); end
        n_checks++; if (err_a !== 3'd2) begin
          n_fail++; $display("FAIL and_err_count: got %0d expected 2", err_a); end
        n_checks++; if (mv_a !== 2'd2) begin
          n_fail++; $display("FAIL and_mismatch_vec: got %0d expected 2", mv_a); end
        n_checks++; if (pass_a !== 1'b0) begin
          n_fail++; $display("FAIL and_pass: got %b expected 0", pass_a); end
      end
    end
    mode = 0;
  endtask

  task automatic test_settle0();
    logic [1:0] exp_gi;
    start_b = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      start_b = 1'b0;
      exp_gi = (k < 8) ? 2'(k / 2) : 2'd0;
      n_checks++; if (gi_b !== exp_gi) begin
        n_fail++; $display("FAIL s0_gate_in k=%0d: got %0d expected %0d", k, gi_b, exp_gi); end
      n_checks++; if (done_b !== (k == 8)) begin
        n_fail++; $display("FAIL s0_done k=%0d: got %b expected %b", k, done_b, (k == 8)); end
      if (k == 8) begin
        n_checks++; if (pass_b !== 1'b1) begin
          n_fail++; $display("FAIL s0_pass: got %b expected 1", pass_b); end
      end
    end
  endtask

  task automatic test_start_during_settle();
    int ndone;
    ndone = 0;
    mode = 0;
    start_a = 1'b1;
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      start_a = (k == 4);
      if (done_a === 1'b1) ndone++;
      n_checks++; if (done_a !== (k == 16)) begin
        n_fail++; $display("FAIL restart_done k=%0d: got %b expected %b", k, done_a, (k == 16)); end
    end
    n_checks++; if (ndone !== 1) begin
      n_fail++; $display("FAIL restart_done_count: got %0d expected 1", ndone); end
  endtask

  task automatic test_reset_mid_run();
    mode = 1;
    start_a = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    n_checks++; if ({gi_a, busy_a, err_a, mv_a} !== {2'd2, 1'b1, 3'd1, 2'd1}) begin
      n_fail++; $display("FAIL pre_reset_state: got %b expected %b", {gi_a, busy_a, err_a, mv_a}, {2'd2, 1'b1, 3'd1, 2'd1}); end
    rst = 1'b1;
    #1;
    n_checks++; if ({gi_a, busy_a, done_a, pass_a, err_a, mm_a, mv_a} !== 11'd0) begin
      n_fail++; $display("FAIL async_reset: outputs %b expected 0", {gi_a, busy_a, done_a, pass_a, err_a, mm_a, mv_a}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mode = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin
        n_fail++; $display("FAIL aborted_run k=%0d: done %b busy %b expected 0 0", k, done_a, busy_a); end
    end
    test_or_pass();
  endtask

  task automatic test_back_to_back();
    int t_first, t_second, ndone;
    t_first = -1; t_second = -1; ndone = 0;
    mode = 2;
    start_a = 1'b1;
    for (int k = 0; k < 41; k++) begin
      @(negedge clk);
      if (k == 30) start_a = 1'b0;
      if (done_a === 1'b1) begin
        ndone++;
        if (t_first < 0) t_first = k; else t_second = k;
        n_checks++; if (err_a !== 3'd3) begin
          n_fail++; $display("FAIL b2b_err_count k=%0d: got %0d expected 3", k, err_a); end
        n_checks++; if (pass_a !== 1'b0) begin
          n_fail++; $display("FAIL b2b_pass k=%0d: got %b expected 0", k, pass_a); end
      end
      if (k == 17) begin
        n_checks++; if (err_a !== 3'd0 || busy_a !== 1'b1) begin
          n_fail++; $display("FAIL b2b_restart: err %0d busy %b expected 0 1", err_a, busy_a); end
      end
    end
    n_checks++; if (ndone !== 2 || t_first !== 16 || t_second !== 33) begin
      n_fail++; $display("FAIL b2b_done_timing: count %0d at %0d,%0d expected 2 at 16,33", ndone, t_first, t_second); end
    mode = 0;
  endtask

  initial begin
    test_reset();
    test_or_pass();
    test_and_mismatch();
    test_settle0();
    test_start_during_settle();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
